// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser slice.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } parser_state_t;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// Valid/ready payload byte stream leaving the frame parser.
interface uart_rx_frame_parser_if;
  logic       o_Data_Valid;
  logic       i_Data_Ready;
  logic [7:0] o_Data;
  logic       o_Data_Last;

  modport master (output o_Data_Valid, output o_Data, output o_Data_Last, input i_Data_Ready);
  modport slave  (input o_Data_Valid, input o_Data, input o_Data_Last, output i_Data_Ready);
endinterface

// File: rtl/uart_frame_buf.sv
// Payload register file: synchronous write, combinational read, storage not reset.
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind a UART receiver: SOF, LEN, payload, XOR checksum, then drain.
// Optional inter-byte timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_Rx_Done,
  input  logic [7:0]                    i_Rx_Byte,
  uart_rx_frame_parser_if.master        stream,
  output logic                          o_Frame_Ok,
  output logic                          o_Frame_Err,
  output logic [1:0]                    o_Err_Code,
  output logic                          o_Overrun,
  input  logic                          i_Clr_Overrun
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_rx_frame_parser: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 2");
  end

  parser_state_t    state, state_nxt;
  logic [IDX_W-1:0] len_q, wr_idx, rd_idx, last_idx;
  logic [7:0]       chk_q;
  logic [7:0]       rd_byte;
  logic             buf_we;
  logic             ok_set, err_set;
  logic [1:0]       err_code_nxt;
  logic             len_bad;
  logic             data_vld, accept, last_byte;
  logic             tmo_hit;

  assign last_idx  = len_q - IDX_W'(1);
  assign len_bad   = (i_Rx_Byte == 8'd0) || (i_Rx_Byte > 8'(MAX_LEN));
  assign data_vld  = (state == DRAIN);
  assign accept    = data_vld && stream.i_Data_Ready;
  assign last_byte = (rd_idx == last_idx);

  assign stream.o_Data_Valid = data_vld;
  assign stream.o_Data       = data_vld ? rd_byte : 8'd0;
  assign stream.o_Data_Last  = data_vld && last_byte;

  uart_frame_buf #(.DEPTH(MAX_LEN), .ADDR_W(BUF_AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_idx[BUF_AW-1:0]),
    .wdata (i_Rx_Byte),
    .raddr (rd_idx[BUF_AW-1:0]),
    .rdata (rd_byte)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] gap_cnt;
  logic             gap_run;

  assign gap_run = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  // Fires on the TIMEOUT_CYCLES-th consecutive idle edge inside a frame.
  assign tmo_hit = gap_run && !i_Rx_Done && (gap_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if (i_Rx_Done || !gap_run) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    buf_we       = 1'b0;
    ok_set       = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = o_Err_Code;
    if (tmo_hit) begin
      state_nxt    = HUNT;
      err_set      = 1'b1;
      err_code_nxt = ERR_TMO;
    end else begin
      case (state)
        HUNT: begin
          if (i_Rx_Done && (i_Rx_Byte == SOF_BYTE)) state_nxt = LEN;
        end
        LEN: begin
          if (i_Rx_Done) begin
            if (len_bad) begin
              state_nxt    = HUNT;
              err_set      = 1'b1;
              err_code_nxt = ERR_LEN;
            end else begin
              state_nxt = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (i_Rx_Done) begin
            buf_we = 1'b1;
            if (wr_idx == last_idx) state_nxt = CHK;
          end
        end
        CHK: begin
          if (i_Rx_Done) begin
            if (i_Rx_Byte == chk_q) begin
              state_nxt = DRAIN;
              ok_set    = 1'b1;
            end else begin
              state_nxt    = HUNT;
              err_set      = 1'b1;
              err_code_nxt = ERR_CHK;
            end
          end
        end
        DRAIN: begin
          if (accept && last_byte) state_nxt = HUNT;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      len_q       <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      chk_q       <= 8'd0;
      o_Frame_Ok  <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Err_Code  <= 2'd0;
      o_Overrun   <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_Frame_Ok  <= ok_set;
      o_Frame_Err <= err_set;
      o_Err_Code  <= err_code_nxt;
      if ((state == LEN) && i_Rx_Done && !tmo_hit) begin
        len_q  <= i_Rx_Byte[IDX_W-1:0];
        chk_q  <= i_Rx_Byte;
        wr_idx <= '0;
        rd_idx <= '0;
      end
      if (buf_we) begin
        chk_q  <= chk_q ^ i_Rx_Byte;
        wr_idx <= wr_idx + IDX_W'(1);
      end
      if (accept) rd_idx <= rd_idx + IDX_W'(1);
      // Bytes arriving while draining are dropped; setting beats clearing.
      if (data_vld && i_Rx_Done) begin
        o_Overrun <= 1'b1;
      end else if (i_Clr_Overrun) begin
        o_Overrun <= 1'b0;
      end
    end
  end

endmodule
